// File: rtl/cdc_hs_pkg.sv
// -----------------------------------------------------------------------------
// cdc_hs_pkg
// Shared constants for the destination end of the toggle req/ack crossing:
// the receive FSM state encodings and the counter widths used by the top.
// -----------------------------------------------------------------------------
package cdc_hs_pkg;

  // Receive FSM state encodings (2-bit).
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  // Settle counter width. It covers SETTLE values 0..15.
  localparam int SETTLE_CNT_W = 4;

  // Saturating protocol-violation counter width.
  localparam int ERR_CNT_W = 8;

endpackage : cdc_hs_pkg

// File: rtl/cdc_hs_buf2.sv
// -----------------------------------------------------------------------------
// cdc_hs_buf2
// Two-entry FIFO that holds captured words until the consumer takes them.
// Pointers carry one extra wrap bit, so full and empty can be told apart.
// A write into a full FIFO is accepted when a read in the same cycle frees
// a slot. A read from an empty FIFO is ignored.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    write request and word
//   full              no free slot (ignores a read in the same cycle)
//   rd_en             pop the head word
//   rd_data           head word; stable until it is popped
//   empty             no word held
// -----------------------------------------------------------------------------
module cdc_hs_buf2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  do_rd, do_wr;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[1] != rd_ptr_q[1]) && (wr_ptr_q[0] == rd_ptr_q[0]);
  assign rd_data = mem_q[rd_ptr_q[0]];

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  // NOTE: every always_comb output gets a default first; a missing branch
  // assignment would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_wr) begin
      mem_d[wr_ptr_q[0]] = wr_data;
      wr_ptr_d           = wr_ptr_q + 2'd1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
  end

  // NOTE: the two storage words are reset as well, because out_data must
  // read as zero after reset and not as an unknown value.
  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule : cdc_hs_buf2

// File: rtl/cdc_handshake_rx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_rx
// Destination end of a toggle req/ack bus crossing. A new request is a
// difference between the synchronized req level and the last acknowledged
// level (req_seen). After SETTLE extra cycles the source-held data_in is
// sampled into a 2-entry buffer, and ack_tgl is toggled. Because of the
// buffer, ack can return before the consumer takes the word.
//
// Optional feature (macro CDC_HS_RX_ERR_EN): adds err_overrun (sticky) and
// err_count (saturating). Both flag req_tgl_sync changing while a request
// is still in SETTLE or CAPTURE. With the macro undefined, the ports and
// the logic are absent.
//
// Ports
//   clk, rst_n     destination clock, asynchronous active-low reset
//   req_tgl_sync   req toggle, already synchronized into clk
//   data_in        source data, held from the req toggle until ack is seen
//   ack_tgl        registered ack toggle back to the source domain
//   out_valid      out_data holds a captured word
//   out_data       head word of the buffer
//   out_ready      consumer takes the head word when out_valid & out_ready
//   err_overrun    (CDC_HS_RX_ERR_EN) sticky protocol-violation flag
//   err_count      (CDC_HS_RX_ERR_EN) saturating violation count
// -----------------------------------------------------------------------------
module cdc_handshake_rx
  import cdc_hs_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_tgl_sync,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 ack_tgl,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready
`ifdef CDC_HS_RX_ERR_EN
  ,
  output logic                 err_overrun,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  // Last count value spent in SETTLE. The value is only used when SETTLE > 0.
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST =
    SETTLE_CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  logic [1:0]              state_q, state_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    req_seen_q, req_seen_d;
  logic                    ack_q, ack_d;

  logic pending;
  logic buf_wr, buf_full, buf_empty, buf_space;

  assign pending = req_tgl_sync ^ req_seen_q;

  // A pop in this cycle frees a slot in time for the capture.
  assign buf_space = ~buf_full | (out_ready & ~buf_empty);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    buf_wr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          cnt_d   = '0;
          state_d = (SETTLE > 0) ? ST_SETTLE : ST_CAPTURE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_CAPTURE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      ST_CAPTURE: begin
        // With the buffer full, wait here without ack. The source keeps
        // data_in stable until it sees the ack.
        if (buf_space) begin
          buf_wr     = 1'b1;
          ack_d      = ~ack_q;
          req_seen_d = ~req_seen_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
    end
  end

  assign ack_tgl = ack_q;

  cdc_hs_buf2 #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_wr),
    .wr_data (data_in),
    .full    (buf_full),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .empty   (buf_empty)
  );

  assign out_valid = ~buf_empty;

`ifdef CDC_HS_RX_ERR_EN
  logic                 req_prev_q, req_prev_d;
  logic                 err_overrun_q, err_overrun_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 violation;

  // While a request is in flight, the source must not toggle req again.
  // req_prev_q holds the level from the previous cycle, so the toggle that
  // opens a request is seen in IDLE and is not counted.
  assign violation = (req_tgl_sync ^ req_prev_q) &
                     ((state_q == ST_SETTLE) || (state_q == ST_CAPTURE));

  always_comb begin
    req_prev_d    = req_tgl_sync;
    err_overrun_d = err_overrun_q | violation;
    err_count_d   = err_count_q;
    if (violation && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev_q    <= 1'b0;
      err_overrun_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      req_prev_q    <= req_prev_d;
      err_overrun_q <= err_overrun_d;
      err_count_q   <= err_count_d;
    end
  end

  assign err_overrun = err_overrun_q;
  assign err_count   = err_count_q;
`endif

endmodule : cdc_handshake_rx

// File: tb/tb_cdc_handshake_rx.sv
// -----------------------------------------------------------------------------
// tb_cdc_handshake_rx
// Directed bench for cdc_handshake_rx. Instance u_dut_a uses SETTLE=1 for
// the reset, latency and back-pressure scenarios. Instance u_dut_b uses
// SETTLE=0 and a loopback source for the back-to-back stream. Inputs are
// driven, and outputs sampled, 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_cdc_handshake_rx;

  localparam int WIDTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             req_a = 1'b0;
  logic [WIDTH-1:0] data_a = '0;
  logic             out_ready_a = 1'b0;
  logic             ack_a, valid_a;
  logic [WIDTH-1:0] odata_a;

  logic             req_b = 1'b0;
  logic [WIDTH-1:0] data_b = '0;
  logic             out_ready_b = 1'b0;
  logic             ack_b, valid_b;
  logic [WIDTH-1:0] odata_b;

`ifdef CDC_HS_RX_ERR_EN
  logic       err_ovr_a, err_ovr_b;
  logic [7:0] err_cnt_a, err_cnt_b;
`endif

  cdc_handshake_rx #(.WIDTH(WIDTH), .SETTLE(1)) u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_tgl_sync (req_a),
    .data_in      (data_a),
    .ack_tgl      (ack_a),
    .out_valid    (valid_a),
    .out_data     (odata_a),
    .out_ready    (out_ready_a)
`ifdef CDC_HS_RX_ERR_EN
    ,
    .err_overrun  (err_ovr_a),
    .err_count    (err_cnt_a)
`endif
  );

  cdc_handshake_rx #(.WIDTH(WIDTH), .SETTLE(0)) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_tgl_sync (req_b),
    .data_in      (data_b),
    .ack_tgl      (ack_b),
    .out_valid    (valid_b),
    .out_data     (odata_b),
    .out_ready    (out_ready_b)
`ifdef CDC_HS_RX_ERR_EN
    ,
    .err_overrun  (err_ovr_b),
    .err_count    (err_cnt_b)
`endif
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_ack_a = 1'b0;

  // Wait for ack_a to leave 'prev'. Returns the number of edges waited,
  // or -1 if the budget runs out.
  task automatic wait_ack_a(input logic prev, input int budget, output int cycles);
    cycles = 0;
    while (ack_a === prev && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (ack_a === prev) cycles = -1;
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL por_ack_a: got %b want 0", ack_a); end
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL por_valid_a: got %b want 0", valid_a); end
    n_checks++; if (odata_a !== '0) begin n_fail++; $display("FAIL por_data_a: got %h want 0", odata_a); end
    n_checks++; if (ack_b !== 1'b0 || valid_b !== 1'b0) begin n_fail++; $display("FAIL por_b: got ack %b valid %b want 0 0", ack_b, valid_b); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Buffer one word (ack goes to 1), then stop the next request in CAPTURE.
    out_ready_a = 1'b0;
    data_a = 32'h1111_0001;
    req_a  = 1'b1;
    wait_ack_a(1'b0, 10, cyc);
    n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL rst_setup_latency: got %0d want 3", cyc); end
    data_a = 32'h1111_0002;
    req_a  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    n_checks++; if (ack_a !== 1'b1 || valid_a !== 1'b1) begin n_fail++; $display("FAIL pre_reset_state: got ack %b valid %b want 1 1", ack_a, valid_a); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL midop_ack: got %b want 0", ack_a); end
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL midop_valid: got %b want 0", valid_a); end
    n_checks++; if (odata_a !== '0) begin n_fail++; $display("FAIL midop_data: got %h want 0", odata_a); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ack_a = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (valid_a !== 1'b0 || ack_a !== 1'b0) begin n_fail++; $display("FAIL post_reset: got ack %b valid %b want 0 0", ack_a, valid_a); end
  endtask

  task automatic test_single();
    out_ready_a = 1'b1;
    data_a = 32'hA5A5_0001;
    req_a  = ~req_a;
    exp_ack_a = ~exp_ack_a;
    @(posedge clk); #1;  // edge N
    n_checks++; if (ack_a === exp_ack_a || valid_a !== 1'b0) begin n_fail++; $display("FAIL single_edge_n: got ack %b valid %b, ack must not toggle yet", ack_a, valid_a); end
    @(posedge clk); #1;  // edge N+1
    n_checks++; if (ack_a === exp_ack_a || valid_a !== 1'b0) begin n_fail++; $display("FAIL single_edge_n1: got ack %b valid %b, ack must not toggle yet", ack_a, valid_a); end
    @(posedge clk); #1;  // edge N+2
    n_checks++; if (ack_a !== exp_ack_a) begin n_fail++; $display("FAIL single_ack: got %b want %b", ack_a, exp_ack_a); end
    n_checks++; if (valid_a !== 1'b1 || odata_a !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_word: got valid %b data %h want 1 a5a50001", valid_a, odata_a); end
    @(posedge clk); #1;  // edge N+3, word popped
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL single_pop: got valid %b want 0", valid_a); end
  endtask

  // Fill both slots, then hold a third request until a pop frees a slot.
  // 'pulse' pops once and then stalls, checking that the head word stays put.
  task automatic fill_and_hold(input logic [WIDTH-1:0] base, input bit pulse);
    int cyc;
    out_ready_a = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      data_a = base + WIDTH'(k);
      req_a  = ~req_a;
      wait_ack_a(exp_ack_a, 10, cyc);
      exp_ack_a = ~exp_ack_a;
      n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL fill_latency_%0d: got %0d want 3", k, cyc); end
    end
    n_checks++; if (valid_a !== 1'b1 || odata_a !== base + 1) begin n_fail++; $display("FAIL fill_head: got valid %b data %h want 1 %h", valid_a, odata_a, base + 1); end
    data_a = base + 3;
    req_a  = ~req_a;
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (ack_a !== exp_ack_a) begin n_fail++; $display("FAIL full_no_ack: got %b want %b", ack_a, exp_ack_a); end
    n_checks++; if (odata_a !== base + 1) begin n_fail++; $display("FAIL full_head_stable: got %h want %h", odata_a, base + 1); end
    out_ready_a = 1'b1;
    @(posedge clk); #1;  // pop word 1, capture word 3 at the same edge
    exp_ack_a = ~exp_ack_a;
    if (pulse) out_ready_a = 1'b0;
    n_checks++; if (ack_a !== exp_ack_a) begin n_fail++; $display("FAIL pop_capture_ack: got %b want %b", ack_a, exp_ack_a); end
    n_checks++; if (valid_a !== 1'b1 || odata_a !== base + 2) begin n_fail++; $display("FAIL pop_capture_head: got valid %b data %h want 1 %h", valid_a, odata_a, base + 2); end
    if (pulse) begin
      repeat (3) begin
        @(posedge clk); #1;
        n_checks++; if (valid_a !== 1'b1 || odata_a !== base + 2) begin n_fail++; $display("FAIL stall_head: got valid %b data %h want 1 %h", valid_a, odata_a, base + 2); end
      end
      out_ready_a = 1'b1;
    end
    @(posedge clk); #1;
    n_checks++; if (valid_a !== 1'b1 || odata_a !== base + 3) begin n_fail++; $display("FAIL third_word: got valid %b data %h want 1 %h", valid_a, odata_a, base + 3); end
    @(posedge clk); #1;
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL drained: got valid %b want 0", valid_a); end
    n_checks++; if (ack_a !== exp_ack_a) begin n_fail++; $display("FAIL no_dup_ack: got %b want %b", ack_a, exp_ack_a); end
  endtask

  task automatic test_backpressure();
    fill_and_hold(32'h0000_0000, 1'b0);
  endtask

  task automatic test_full_pop_capture();
    fill_and_hold(32'h0000_0010, 1'b1);
  endtask

  task automatic test_back_to_back();
    int rcv = 0;
    int min_lat = 1000;
    int max_lat = 0;
    out_ready_b = 1'b1;
    fork
      begin : source
        for (int i = 0; i < 100; i++) begin
          logic prev;
          int   cyc;
          prev   = ack_b;
          data_b = 32'hB000_0000 + WIDTH'(i);
          req_b  = ~req_b;
          cyc    = 0;
          while (ack_b === prev && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
          end
          if (ack_b === prev) begin
            n_checks++; n_fail++;
            $display("FAIL b2b_ack_timeout: word %0d got no ack in %0d cycles", i, cyc);
            break;
          end
          if (cyc < min_lat) min_lat = cyc;
          if (cyc > max_lat) max_lat = cyc;
        end
      end
      begin : consumer
        for (int c = 0; c < 400 && rcv < 100; c++) begin
          @(posedge clk); #1;
          if (valid_b === 1'b1) begin
            n_checks++;
            if (odata_b !== 32'hB000_0000 + WIDTH'(rcv)) begin
              n_fail++;
              $display("FAIL b2b_order: word %0d got %h want %h", rcv, odata_b, 32'hB000_0000 + WIDTH'(rcv));
            end
            rcv++;
          end
        end
      end
    join
    n_checks++; if (rcv != 100) begin n_fail++; $display("FAIL b2b_count: got %0d want 100", rcv); end
    n_checks++; if (min_lat != 2 || max_lat != 2) begin n_fail++; $display("FAIL b2b_rate: got latency %0d..%0d want 2..2", min_lat, max_lat); end
  endtask

`ifdef CDC_HS_RX_ERR_EN
  // Toggle req, then toggle it back while the request sits in SETTLE.
  task automatic violate_once();
    req_a = ~req_a;
    @(posedge clk); #1;
    req_a = ~req_a;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_err();
    out_ready_a = 1'b1;
    n_checks++; if (err_ovr_a !== 1'b0 || err_cnt_a !== 8'd0) begin n_fail++; $display("FAIL err_initial: got ovr %b cnt %0d want 0 0", err_ovr_a, err_cnt_a); end
    violate_once();
    n_checks++; if (err_ovr_a !== 1'b1) begin n_fail++; $display("FAIL err_overrun: got %b want 1", err_ovr_a); end
    n_checks++; if (err_cnt_a !== 8'd1) begin n_fail++; $display("FAIL err_count_1: got %0d want 1", err_cnt_a); end
    for (int i = 0; i < 300; i++) violate_once();
    n_checks++; if (err_cnt_a !== 8'd255) begin n_fail++; $display("FAIL err_count_sat: got %0d want 255", err_cnt_a); end
    n_checks++; if (err_ovr_a !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_ovr_a); end
    // Each violation yields two captures, so the ack parity is unchanged.
    n_checks++; if (ack_a !== exp_ack_a || valid_a !== 1'b0) begin n_fail++; $display("FAIL err_datapath: got ack %b valid %b want %b 0", ack_a, valid_a, exp_ack_a); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full_pop_capture();
    test_back_to_back();
`ifdef CDC_HS_RX_ERR_EN
    test_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cdc_handshake_rx
